isodata_result_streamer: RTL and testbench
==========================================

// Module: isodata_result_streamer
// PURPOSE
//  Reads the clustering result (centroids, per-sink cluster IDs, sink coordinates) after clustering completes.
//  Serialises it as a valid/ready beat stream, one packet per cluster: a header beat, then one beat per member sink.
//  Sits downstream of the ISODATA clusterer and feeds the CTS buffer-placement / routing stage.
// PARAMETERS
//  N_SINKS       128  number of sinks
//  MAX_CLUSTERS  16   cluster slots
//  WIDTH         16   coordinate width, signed Q8.8
// PORTS
//  clk           in   1                    clock
//  rst           in   1                    asynchronous active-high reset
//  start         in   1                    pulse; begin streaming (ignored unless IDLE)
//  num_clusters  in   $clog2(MAX_CLUSTERS)+1  active cluster count
//  centroid_x/y  in   WIDTH x MAX_CLUSTERS  signed centroids
//  assignments   in   $clog2(MAX_CLUSTERS) x N_SINKS  cluster ID per sink
//  sink_x/y      in   WIDTH x N_SINKS       signed sink coordinates
//  out_valid     out  1                    beat valid
//  out_ready     in   1                    downstream accept
//  out_hdr       out  1                    1 = header beat, 0 = member beat
//  out_idx       out  $clog2(N_SINKS)      header: cluster ID (zero-extended); member: sink index
//  out_x/out_y   out  WIDTH                header: centroid; member: sink coords
//  out_count     out  $clog2(N_SINKS)+1    header: member count; member: 0
//  out_last      out  1                    last beat of the current cluster packet
//  busy          out  1                    high from accepted start until done
//  done          out  1                    one-cycle pulse after the final beat
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE. Reset mid-stream aborts at once; out_valid drops asynchronously.
//  Inputs are held stable by upstream while busy; the block takes no snapshot.
//  Effective K = min(num_clusters, MAX_CLUSTERS). If K == 0: done pulses the cycle after start; no beats.
//  FSM: IDLE -> COUNT -> HDR -> SCAN -> (next k: COUNT | all k done: FIN) -> IDLE.
//   COUNT: one sink per cycle, i = 0..N_SINKS-1; cnt += (assignments[i] == k). N_SINKS cycles.
//   HDR: drive header {k, centroid_x/y[k], cnt}; wait for handshake; out_last = (cnt == 0).
//    If cnt == 0 and CLUSTER_EMPTY_HDR_EN is undefined, skip HDR/SCAN and go straight to the next k.
//   SCAN: i = 0..N_SINKS-1. Non-members are skipped at 1 cycle each.
//    Members drive {i, sink_x/y[i]} and hold until handshake.
//    out_last on the member whose ordinal == cnt.
//    SCAN ends after i == N_SINKS-1 is consumed.
//   FIN: done = 1 for one cycle; busy = 0; return to IDLE.
//  Handshake: beat transfers when out_valid && out_ready. While valid && !ready, every out_* is stable.
//   out_valid never drops without a transfer, except on reset.
//  Member and header order: ascending cluster ID; members in ascending sink index.
//  Assignments >= K are never emitted and are excluded from all counts.
//  start while busy: ignored. start and final-beat handshake in the same cycle: start ignored.
//  Counters: cnt and ordinal are $clog2(N_SINKS)+1 bits, so they cannot overflow.
//  Min latency per non-empty cluster: 2*N_SINKS + 1 cycles.
// CONFIGURATION
//  CLUSTER_EMPTY_HDR_EN defined: an empty cluster (< K) emits a header with out_count = 0 and out_last = 1.
//  CLUSTER_EMPTY_HDR_EN undefined: an empty cluster emits no beats.
// STRUCTURE
//  Package isodata_pkg: beat_kind_t {BEAT_HDR, BEAT_MEMBER}; stream_state_t;
//   struct cluster_beat_t {hdr, idx, x, y, count, last}; width localparams CID_W, SID_W, CNT_W.
//  Sub-module isodata_member_counter: sequential match-counter for the COUNT pass
//   (k, assignment stream in; cnt, last-index flag out). Reused by other CTS blocks.
// TESTING
//  N_SINKS=8, K=2, assign={0,1,0,1,0,0,1,0}, ready=1 ->
//   HDR k0 cnt5; members 0,2,4,5,7 (last on 7); HDR k1 cnt3; members 1,3,6 (last on 6); done x1.
//  Same stimulus with ready toggling 1,0,1,0 -> identical beat sequence; out_* stable during each stall.
//  K=3, no sink assigned to 2 -> macro undefined: 2 packets only.
//   Macro defined: third HDR {idx=2, cnt=0, last=1}.
//  num_clusters=0, start -> done pulse the next cycle; out_valid stays 0.
//  Reset asserted after 3 accepted beats -> out_valid=0, busy=0 immediately;
//   the next start replays the full stream from HDR k0.
//  assign[3]=5 with K=2, plus a start pulse mid-stream -> sink 3 is never emitted, counts exclude it,
//   and the second start has no effect.

Source files
------------

// File: rtl/isodata_pkg.sv
// Shared types and default widths for the ISODATA result streamer and its helper blocks.
package isodata_pkg;
  localparam int N_SINKS_DEF      = 128;
  localparam int MAX_CLUSTERS_DEF = 16;
  localparam int WIDTH_DEF        = 16;

  localparam int CID_W = $clog2(MAX_CLUSTERS_DEF);
  localparam int SID_W = $clog2(N_SINKS_DEF);
  localparam int CNT_W = SID_W + 1;

  typedef enum logic {BEAT_HDR, BEAT_MEMBER} beat_kind_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_HDR,
    ST_SCAN,
    ST_FIN
  } stream_state_t;

  // One output beat at the default sizes.
  typedef struct packed {
    beat_kind_t           hdr;
    logic [SID_W-1:0]     idx;
    logic [WIDTH_DEF-1:0] x;
    logic [WIDTH_DEF-1:0] y;
    logic [CNT_W-1:0]     count;
    logic                 last;
  } cluster_beat_t;
endpackage

// File: rtl/isodata_member_counter.sv
// Sequential match counter: accumulates how many streamed cluster IDs equal k, one per enabled cycle.
module isodata_member_counter
  import isodata_pkg::*;
#(
  parameter int  N_SINKS      = N_SINKS_DEF,
  parameter int  MAX_CLUSTERS = MAX_CLUSTERS_DEF,
  localparam int CIDB         = $clog2(MAX_CLUSTERS),
  localparam int SIDB         = $clog2(N_SINKS),
  localparam int CNTB         = SIDB + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [CIDB-1:0] k_i,
  input  logic [CIDB-1:0] asg_i,
  input  logic [SIDB-1:0] idx_i,
  output logic [CNTB-1:0] cnt_o,
  output logic [CNTB-1:0] cnt_nxt_o,
  output logic            last_o
);

  logic [CNTB-1:0] cnt_q, cnt_d, cnt_sum;

  // cnt_nxt_o ignores clr_i so a caller may decide to clear based on it without a loop.
  assign cnt_sum = cnt_q + CNTB'(en_i && (asg_i == k_i));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_sum;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign cnt_nxt_o = cnt_sum;
  assign last_o    = (idx_i == SIDB'(N_SINKS - 1));

endmodule

// File: rtl/isodata_result_streamer.sv
// Streams the ISODATA clustering result as one header + member-beat packet per cluster.
// Build option CLUSTER_EMPTY_HDR_EN: empty clusters emit a zero-count header instead of nothing.
//   state | meaning
//   IDLE  | waiting for start
//   COUNT | counting members of cluster k, one sink per cycle
//   HDR   | presenting the header beat of cluster k
//   SCAN  | walking sinks, presenting members of cluster k
//   FIN   | one-cycle done pulse
module isodata_result_streamer
  import isodata_pkg::*;
#(
  parameter int  N_SINKS      = N_SINKS_DEF,
  parameter int  MAX_CLUSTERS = MAX_CLUSTERS_DEF,
  parameter int  WIDTH        = WIDTH_DEF,
  localparam int CIDB         = $clog2(MAX_CLUSTERS),
  localparam int SIDB         = $clog2(N_SINKS),
  localparam int CNTB         = SIDB + 1,
  localparam int NCB          = CIDB + 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [NCB-1:0]                       num_clusters_i,
  input  logic [MAX_CLUSTERS-1:0][WIDTH-1:0]   centroid_x_i,
  input  logic [MAX_CLUSTERS-1:0][WIDTH-1:0]   centroid_y_i,
  input  logic [N_SINKS-1:0][CIDB-1:0]         assignments_i,
  input  logic [N_SINKS-1:0][WIDTH-1:0]        sink_x_i,
  input  logic [N_SINKS-1:0][WIDTH-1:0]        sink_y_i,
  output logic                                 out_valid_o,
  input  logic                                 out_ready_i,
  output logic                                 out_hdr_o,
  output logic [SIDB-1:0]                      out_idx_o,
  output logic [WIDTH-1:0]                     out_x_o,
  output logic [WIDTH-1:0]                     out_y_o,
  output logic [CNTB-1:0]                      out_count_o,
  output logic                                 out_last_o,
  output logic                                 busy_o,
  output logic                                 done_o
);

`ifdef CLUSTER_EMPTY_HDR_EN
  localparam bit EMPTY_HDR = 1'b1;
`else
  localparam bit EMPTY_HDR = 1'b0;
`endif

  stream_state_t   state_q, state_d;
  logic [CIDB-1:0] k_q, k_d;
  logic [SIDB-1:0] i_q, i_d;
  logic [CNTB-1:0] ord_q, ord_d;

  logic [NCB-1:0]  k_eff;
  logic [CIDB-1:0] asg_cur;
  logic            last_k, is_member, adv_k, step;
  logic            cnt_clr, cnt_en, idx_last;
  logic [CNTB-1:0] cnt, cnt_nxt;

  beat_kind_t      kind;
  logic            valid, last;
  logic [SIDB-1:0] idx;
  logic [WIDTH-1:0] bx, by;
  logic [CNTB-1:0] bcnt;

  assign k_eff     = (num_clusters_i > NCB'(MAX_CLUSTERS)) ? NCB'(MAX_CLUSTERS) : num_clusters_i;
  assign last_k    = (({1'b0, k_q} + NCB'(1)) >= k_eff);
  assign asg_cur   = assignments_i[i_q];
  assign is_member = (asg_cur == k_q);

  isodata_member_counter #(
    .N_SINKS      (N_SINKS),
    .MAX_CLUSTERS (MAX_CLUSTERS)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .k_i       (k_q),
    .asg_i     (asg_cur),
    .idx_i     (i_q),
    .cnt_o     (cnt),
    .cnt_nxt_o (cnt_nxt),
    .last_o    (idx_last)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    ord_d   = ord_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    adv_k   = 1'b0;
    step    = 1'b0;
    valid   = 1'b0;
    kind    = BEAT_MEMBER;
    idx     = '0;
    bx      = '0;
    by      = '0;
    bcnt    = '0;
    last    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          k_d     = '0;
          i_d     = '0;
          cnt_clr = 1'b1;
          state_d = (k_eff == '0) ? ST_FIN : ST_COUNT;
        end
      end

      ST_COUNT: begin
        cnt_en = 1'b1;
        i_d    = i_q + SIDB'(1);
        if (idx_last) begin
          i_d = '0;
          // The final count is only known combinationally on the last COUNT cycle.
          if ((cnt_nxt == '0) && !EMPTY_HDR) begin
            adv_k = 1'b1;
          end else begin
            state_d = ST_HDR;
          end
        end
      end

      ST_HDR: begin
        valid = 1'b1;
        kind  = BEAT_HDR;
        idx   = SIDB'(k_q);
        bx    = centroid_x_i[k_q];
        by    = centroid_y_i[k_q];
        bcnt  = cnt;
        last  = (cnt == '0);
        if (out_ready_i) begin
          if (cnt == '0) begin
            adv_k = 1'b1;
          end else begin
            state_d = ST_SCAN;
            i_d     = '0;
            ord_d   = '0;
          end
        end
      end

      ST_SCAN: begin
        if (is_member) begin
          valid = 1'b1;
          idx   = i_q;
          bx    = sink_x_i[i_q];
          by    = sink_y_i[i_q];
          last  = ((ord_q + CNTB'(1)) == cnt);
          if (out_ready_i) begin
            ord_d = ord_q + CNTB'(1);
            step  = 1'b1;
          end
        end else begin
          step = 1'b1;
        end
        if (step) begin
          if (idx_last) begin
            adv_k = 1'b1;
          end else begin
            i_d = i_q + SIDB'(1);
          end
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (adv_k) begin
      i_d = '0;
      if (last_k) begin
        state_d = ST_FIN;
      end else begin
        state_d = ST_COUNT;
        k_d     = k_q + CIDB'(1);
        cnt_clr = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      ord_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      ord_q   <= ord_d;
    end
  end

  assign out_valid_o = valid;
  assign out_hdr_o   = valid && (kind == BEAT_HDR);
  assign out_idx_o   = idx;
  assign out_x_o     = bx;
  assign out_y_o     = by;
  assign out_count_o = bcnt;
  assign out_last_o  = last;
  assign busy_o      = (state_q == ST_COUNT) || (state_q == ST_HDR) || (state_q == ST_SCAN);
  assign done_o      = (state_q == ST_FIN);

endmodule

// File: tb/tb_isodata_result_streamer.sv
// Self-checking bench for isodata_result_streamer: queue-based packet model plus literal pins.
module tb_isodata_result_streamer;
  import isodata_pkg::*;

  localparam int NS   = 8;
  localparam int MC   = 16;
  localparam int W    = 16;
  localparam int CIDB = 4;
  localparam int SIDB = 3;
  localparam int CNTB = 4;

`ifdef CLUSTER_EMPTY_HDR_EN
  localparam bit EMPTY_HDR = 1'b1;
`else
  localparam bit EMPTY_HDR = 1'b0;
`endif

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       start;
  logic [CIDB:0]              num_clusters;
  logic [MC-1:0][W-1:0]       cx, cy;
  logic [NS-1:0][CIDB-1:0]    asg;
  logic [NS-1:0][W-1:0]       sx, sy;
  logic                       out_valid, out_ready, out_hdr, out_last, busy, done;
  logic [SIDB-1:0]            out_idx;
  logic [W-1:0]               out_x, out_y;
  logic [CNTB-1:0]            out_count;

  always #5 clk = ~clk;

  isodata_result_streamer #(
    .N_SINKS      (NS),
    .MAX_CLUSTERS (MC),
    .WIDTH        (W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start),
    .num_clusters_i (num_clusters),
    .centroid_x_i   (cx),
    .centroid_y_i   (cy),
    .assignments_i  (asg),
    .sink_x_i       (sx),
    .sink_y_i       (sy),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_hdr_o      (out_hdr),
    .out_idx_o      (out_idx),
    .out_x_o        (out_x),
    .out_y_o        (out_y),
    .out_count_o    (out_count),
    .out_last_o     (out_last),
    .busy_o         (busy),
    .done_o         (done)
  );

  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_xfer, n_done, n_stall;
  bit            chk_en = 1'b0;
  bit            prev_stall = 1'b0;
  cluster_beat_t exp_q[$];
  cluster_beat_t got, prev_beat;
  int            seen_idx[$];
  int            golden[$];
  int            pat[NS];

  function automatic void check(input string name, input bit ok, input string info);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, info);
  endfunction

  function automatic string fmt(input cluster_beat_t b);
    return $sformatf("{hdr=%0d idx=%0d x=%h y=%h cnt=%0d last=%0d}",
                     b.hdr == BEAT_HDR, b.idx, b.x, b.y, b.count, b.last);
  endfunction

  function automatic cluster_beat_t mk(input bit h, input int idx, input logic [W-1:0] x,
                                       input logic [W-1:0] y, input int cnt, input bit last);
    cluster_beat_t b;
    b.hdr   = h ? BEAT_HDR : BEAT_MEMBER;
    b.idx   = SID_W'(idx);
    b.x     = x;
    b.y     = y;
    b.count = CNT_W'(cnt);
    b.last  = last;
    return b;
  endfunction

  // Expected beat list straight from the packet rules: per cluster, header then members in index order.
  function automatic void build_model(input int k_in);
    int kk, cnt, ord;
    kk = (k_in > MC) ? MC : k_in;
    exp_q.delete();
    for (int k = 0; k < kk; k++) begin
      cnt = 0;
      ord = 0;
      for (int i = 0; i < NS; i++) if (int'(asg[i]) == k) cnt++;
      if (cnt == 0 && !EMPTY_HDR) continue;
      exp_q.push_back(mk(1'b1, k, cx[k], cy[k], cnt, cnt == 0));
      for (int i = 0; i < NS; i++) begin
        if (int'(asg[i]) == k) begin
          ord++;
          exp_q.push_back(mk(1'b0, i, sx[i], sy[i], 0, ord == cnt));
        end
      end
    end
  endfunction

  function automatic void load_pat();
    for (int i = 0; i < NS; i++) asg[i] = CIDB'(pat[i]);
  endfunction

  function automatic void check_seq(input string name);
    bit ok;
    ok = (seen_idx.size() == golden.size());
    for (int i = 0; i < golden.size() && i < seen_idx.size(); i++)
      if (seen_idx[i] != golden[i]) ok = 1'b0;
    check(name, ok, $sformatf("got idx sequence %p, required %p", seen_idx, golden));
  endfunction

  // Compare process: outputs are stable mid-cycle; ready is changed just after posedge.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      got.hdr   = out_hdr ? BEAT_HDR : BEAT_MEMBER;
      got.idx   = SID_W'(out_idx);
      got.x     = out_x;
      got.y     = out_y;
      got.count = CNT_W'(out_count);
      got.last  = out_last;
      if (prev_stall) begin
        n_stall++;
        check("stall_hold", out_valid && (got == prev_beat),
              $sformatf("got valid=%0d %s, required valid=1 %s", out_valid, fmt(got), fmt(prev_beat)));
      end
      if (out_valid) begin
        check("beat_expected", exp_q.size() != 0, $sformatf("got beat %s, required no beat", fmt(got)));
        if (exp_q.size() != 0)
          check("beat", got == exp_q[0], $sformatf("got %s, required %s", fmt(got), fmt(exp_q[0])));
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          n_xfer++;
          seen_idx.push_back(int'(out_idx));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = got;
      if (done) begin
        n_done++;
        check("done_after_stream", exp_q.size() == 0,
              $sformatf("got done with %0d beats outstanding, required 0", exp_q.size()));
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic run_stream(input int k_in, input bit toggle, input bit mid_start);
    int cyc;
    n_xfer = 0;
    n_done = 0;
    seen_idx.delete();
    num_clusters = CIDB'(k_in) | '0;
    num_clusters = k_in[CIDB:0];
    out_ready = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("busy_after_start", busy == 1'b1, $sformatf("got busy=%0d, required 1", busy));
    cyc = 0;
    while (n_done == 0 && cyc < 600) begin
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      start = mid_start && (cyc == 20);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_seen", n_done == 1, $sformatf("got %0d done pulses within %0d cycles, required 1", n_done, cyc));
    repeat (3) @(posedge clk);
    #1;
    check("single_done", n_done == 1, $sformatf("got %0d done pulses, required 1", n_done));
    check("stream_drained", exp_q.size() == 0, $sformatf("got %0d beats missing, required 0", exp_q.size()));
    check("busy_clear", busy == 1'b0 && out_valid == 1'b0,
          $sformatf("got busy=%0d valid=%0d, required 0 0", busy, out_valid));
    chk_en = 1'b0;
  endtask

  initial begin
    int cyc;
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b0;
    num_clusters = '0;
    for (int k = 0; k < MC; k++) begin
      cx[k] = W'(k * 256 + 17);
      cy[k] = W'(-(k * 128) - 3);
    end
    for (int i = 0; i < NS; i++) begin
      sx[i] = W'(i * 37 - 100);
      sy[i] = W'(500 - i * 13);
    end
    pat = '{0, 1, 0, 1, 0, 0, 1, 0};
    load_pat();

    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs",
          !out_valid && !out_hdr && out_idx == '0 && out_x == '0 && out_y == '0 &&
          out_count == '0 && !out_last && !busy && !done,
          $sformatf("got valid=%0d hdr=%0d idx=%0d x=%h y=%h cnt=%0d last=%0d busy=%0d done=%0d, required all 0",
                    out_valid, out_hdr, out_idx, out_x, out_y, out_count, out_last, busy, done));
    @(negedge clk) rst = 1'b0;

    // Two clusters, ready held high.
    build_model(2);
    check("model_size", exp_q.size() == 10, $sformatf("got %0d beats, required 10", exp_q.size()));
    check("model_hdr_k0", exp_q[0].hdr == BEAT_HDR && exp_q[0].idx == 0 && exp_q[0].count == 5,
          $sformatf("got %s, required hdr k0 cnt5", fmt(exp_q[0])));
    check("model_last_k0", exp_q[5].idx == 7 && exp_q[5].last == 1'b1,
          $sformatf("got %s, required member 7 last", fmt(exp_q[5])));
    check("model_hdr_k1", exp_q[6].idx == 1 && exp_q[6].count == 3,
          $sformatf("got %s, required hdr k1 cnt3", fmt(exp_q[6])));
    check("model_last_k1", exp_q[9].idx == 6 && exp_q[9].last == 1'b1,
          $sformatf("got %s, required member 6 last", fmt(exp_q[9])));
    run_stream(2, 1'b0, 1'b0);
    golden = '{0, 0, 2, 4, 5, 7, 1, 1, 3, 6};
    check_seq("seq_ready_high");

    // Same stream under backpressure.
    n_stall = 0;
    build_model(2);
    run_stream(2, 1'b1, 1'b0);
    check_seq("seq_ready_toggle");
    check("stalls_seen", n_stall > 0, $sformatf("got %0d stall cycles, required >0", n_stall));

    // K=3 with cluster 2 empty.
    build_model(3);
    check("model_size_k3", exp_q.size() == (EMPTY_HDR ? 11 : 10),
          $sformatf("got %0d beats, required %0d", exp_q.size(), EMPTY_HDR ? 11 : 10));
`ifdef CLUSTER_EMPTY_HDR_EN
    check("model_empty_hdr", exp_q[10].hdr == BEAT_HDR && exp_q[10].idx == 2 &&
          exp_q[10].count == 0 && exp_q[10].last == 1'b1,
          $sformatf("got %s, required hdr k2 cnt0 last", fmt(exp_q[10])));
`endif
    run_stream(3, 1'b0, 1'b0);
`ifdef CLUSTER_EMPTY_HDR_EN
    golden = '{0, 0, 2, 4, 5, 7, 1, 1, 3, 6, 2};
`endif
    check_seq("seq_k3");

    // K=0: done the cycle after start, no beats.
    build_model(0);
    n_done = 0;
    num_clusters = '0;
    chk_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("k0_done_next", done == 1'b1 && out_valid == 1'b0,
          $sformatf("got done=%0d valid=%0d, required 1 0", done, out_valid));
    @(posedge clk); #1;
    check("k0_done_pulse", done == 1'b0 && busy == 1'b0 && n_done == 1,
          $sformatf("got done=%0d busy=%0d pulses=%0d, required 0 0 1", done, busy, n_done));
    chk_en = 1'b0;

    // Reset after three accepted beats, then a full replay.
    build_model(2);
    n_xfer = 0;
    n_done = 0;
    seen_idx.delete();
    num_clusters = 5'd2;
    out_ready = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    cyc = 0;
    while (n_xfer < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reset_wait", n_xfer == 3, $sformatf("got %0d beats in %0d cycles, required 3", n_xfer, cyc));
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_abort", out_valid == 1'b0 && busy == 1'b0 && done == 1'b0,
          $sformatf("got valid=%0d busy=%0d done=%0d, required 0 0 0", out_valid, busy, done));
    @(posedge clk); #1 rst = 1'b0;
    build_model(2);
    run_stream(2, 1'b0, 1'b0);
    golden = '{0, 0, 2, 4, 5, 7, 1, 1, 3, 6};
    check_seq("seq_after_reset");

    // Out-of-range assignment plus a start pulse while busy.
    pat = '{0, 1, 0, 5, 0, 0, 1, 0};
    load_pat();
    build_model(2);
    check("model_size_oor", exp_q.size() == 9, $sformatf("got %0d beats, required 9", exp_q.size()));
    check("model_hdr_k1_oor", exp_q[6].idx == 1 && exp_q[6].count == 2,
          $sformatf("got %s, required hdr k1 cnt2", fmt(exp_q[6])));
    run_stream(2, 1'b0, 1'b1);
    golden = '{0, 0, 2, 4, 5, 7, 1, 1, 6};
    check_seq("seq_oor_midstart");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
